// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N-to-1 channel multiplexer with valid/ready
// handshaking on every input and on the output. The arbitration mode is
// fixed at elaboration: round-robin, fixed priority, or external select.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | output register holds no word (out_valid = 0)
// ST_FULL  | output register holds a word awaiting out_ready
module mux_arb_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int MODE     = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    input  logic [SEL_W-1:0]           ext_sel,
    output logic [WIDTH-1:0]           out_data,
    output logic [SEL_W-1:0]           out_chan,
    output logic                       out_valid,
    input  logic                       out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                load_en;
    logic                xfer;
    logic [WIDTH-1:0]    sel_data;

    // One-hot grant from the requests; round-robin uses two passes (at or
    // above ptr first, then from zero) so no modulo arithmetic is needed.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        case (MODE)
            0: begin
                for (int j = 0; j < CHANNELS; j++) begin
                    if (!gnt_any && in_valid[j] && (SEL_W'(j) >= ptr)) begin
                        grant[j] = 1'b1;
                        gnt_idx  = SEL_W'(j);
                        gnt_any  = 1'b1;
                    end
                end
                for (int j = 0; j < CHANNELS; j++) begin
                    if (!gnt_any && in_valid[j]) begin
                        grant[j] = 1'b1;
                        gnt_idx  = SEL_W'(j);
                        gnt_any  = 1'b1;
                    end
                end
            end
            1: begin
                for (int j = 0; j < CHANNELS; j++) begin
                    if (!gnt_any && in_valid[j]) begin
                        grant[j] = 1'b1;
                        gnt_idx  = SEL_W'(j);
                        gnt_any  = 1'b1;
                    end
                end
            end
            2: begin
                // An out-of-range ext_sel matches no channel, so no grant.
                for (int j = 0; j < CHANNELS; j++) begin
                    if (in_valid[j] && (ext_sel == SEL_W'(j))) begin
                        grant[j] = 1'b1;
                        gnt_idx  = SEL_W'(j);
                        gnt_any  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Handshake: the register can take a word when empty or draining.
    // reset_n gates in_ready so producers see no accept during reset.
    always_comb begin
        load_en  = !out_valid || out_ready;
        in_ready = grant & {CHANNELS{load_en & reset_n}};
        xfer     = gnt_any & load_en;
    end

    // AND-OR select of the granted channel's data.
    always_comb begin
        sel_data = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (grant[j]) begin
                sel_data = in_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: only move when the register is allowed to load.
    always_comb begin
        state_nxt = state;
        if (load_en) begin
            state_nxt = gnt_any ? ST_FULL : ST_EMPTY;
        end
    end

    assign out_valid = (state == ST_FULL);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word and round-robin pointer update on a transfer only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_chan <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            out_data <= sel_data;
            out_chan <= gnt_idx;
            ptr      <= (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshaking and a selectable arbitration mode. It generalises the 32-bit, 16-input combinational select tree to arbitrary data width and channel count. It adds round-robin or fixed-priority arbitration, or externally selected channels, behind a single output register stage. It sits between multiple producers (register-file read ports, I/O sources, sprite/state engines) and one consumer, and provides back-pressure to every producer.

## Interface
- WIDTH, 32, data bits per channel.
- CHANNELS, 16, number of input channels; any value ≥ 2, not required to be a power of two.
- SEL_W, $clog2(CHANNELS), channel-index width (derived; do not override).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = external select.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel request.
- in_ready  out  CHANNELS  per-channel accept; at most one bit is high.
- ext_sel  in  SEL_W  channel index used only when MODE = 2.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  out_data/out_chan hold a word.
- out_ready  in  1  consumer accepts the word.

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid | out_ready.
- The grant is a one-hot vector computed combinationally from in_valid, the mode and the pointer.
- in_ready = grant & {CHANNELS{load_en}}.
- A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer: out_data ← channel i data, out_chan ← i, out_valid ← 1.
- If load_en is high with no grant, out_valid ← 0. out_data and out_chan keep their old values.
- While FULL and !out_ready, out_data, out_chan and out_valid are held stable and all in_ready are 0.
- MODE 0: search starts at pointer ptr and proceeds upward with wrap. The first valid channel wins.
  - After a transfer on channel i, ptr ← i+1. When i = CHANNELS-1, ptr wraps to 0.
  - ptr does not change without a transfer.
- MODE 1: the lowest-indexed valid channel wins. ptr is unused.
- MODE 2: grant[ext_sel] = in_valid[ext_sel].
  - If ext_sel ≥ CHANNELS, there is no grant.
  - ext_sel is sampled in the same cycle as the transfer.
- in_valid is not required to be held. A request that drops before its grant is simply not taken.
- Producers must hold in_data stable while in_valid is high and in_ready is low.

## Timing
- Reset (reset_n low, asynchronous assert, synchronous release on the clock edge):
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
  - in_ready = 0 while reset_n is low.
- Latency: a word accepted at edge k appears on out_data/out_valid immediately after edge k (1 cycle).
- Throughput: one word per cycle while out_ready = 1.
- Drain and load in the same cycle: FULL & out_ready & a grant means the old word leaves and the new word loads at the same edge. out_valid stays 1.
- Reset asserted mid-operation discards the held word with no handshake. Pending producers see in_ready = 0.
- No combinational path from in_data to out_data. The only combinational paths to in_ready are from in_valid, ext_sel and out_ready.

## Test plan
- Reset check (CHANNELS=16, WIDTH=32): drive reset_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0. After release, the first transfer is on channel 0 in MODE 0.
- Round-robin fairness (MODE 0, all 16 channels valid, in_data[i]=0x100+i, out_ready=1):
  - out_chan sequence is 0,1,…,15,0. out_data=0x100+out_chan each cycle.
  - Exactly one in_ready bit is high per cycle.
- Back-pressure (MODE 0): load channel 3 with 0xDEADBEEF, then hold out_ready=0 for 5 cycles with channels 4 and 5 valid.
  - out_data stays 0xDEADBEEF, in_ready=0.
  - After out_ready=1: the next words come from 4, then 5, with no bubble.
- Fixed priority (MODE 1, channels 2 and 9 always valid) -> out_chan=2 every cycle and channel 9 is never granted.
- External select (MODE 2, CHANNELS=12, non-power-of-two):
  - ext_sel=7 with in_valid[7]=1 -> out_chan=7.
  - ext_sel=13 -> no in_ready, and out_valid falls to 0 after the drain.
- Wrap and gaps (MODE 0, CHANNELS=5, only channels 4 and 1 valid, ptr=4) -> grants 4, 1, 4, 1. ptr wraps from 4 to 0.
